// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between instruction fetch (IF)
// and load/store (MEM). Each request becomes one byte access per cycle;
// bytes are assembled little-endian into 32-bit words. MEM wins ties.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_len,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state;
  logic              owner_if;   // 1 = current transaction belongs to IF
  logic [ADDR_W-1:0] base;
  logic [1:0]        last;       // index of final byte (N-1)
  logic [31:0]       wdata;
  logic [2:0]        cnt;        // cycles elapsed since the grant edge
  logic [31:0]       asm_data;   // bytes captured so far

  logic [31:0]       assembled;
  logic [1:0]        rd_idx;
  logic [1:0]        wr_idx;
  logic [ADDR_W-1:0] next_addr;
  logic [1:0]        len_last;

  // Byte lanes, next address and the word including this cycle's capture
  always_comb begin
    rd_idx    = cnt[1:0] - 2'd1;
    wr_idx    = cnt[1:0] + 2'd1;
    next_addr = base + {{(ADDR_W-3){1'b0}}, cnt} + {{(ADDR_W-1){1'b0}}, 1'b1};
    assembled = asm_data;
    assembled[{rd_idx, 3'b000} +: 8] = ram_din;
    case (mem_len)
      2'b00:   len_last = 2'd0;
      2'b01:   len_last = 2'd1;
      default: len_last = 2'd3;
    endcase
  end

  // Arbitration FSM with all outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner_if  <= 1'b0;
      base      <= '0;
      last      <= 2'd0;
      wdata     <= 32'd0;
      cnt       <= 3'd0;
      asm_data  <= 32'd0;
      if_done   <= 1'b0;
      if_data   <= 32'd0;
      mem_done  <= 1'b0;
      mem_rdata <= 32'd0;
      ram_a     <= '0;
      ram_wr    <= 1'b0;
      ram_dout  <= 8'd0;
      busy      <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        IDLE: begin
          // MEM holds the older instruction, so it is granted first
          if (mem_req) begin
            owner_if <= 1'b0;
            base     <= mem_addr;
            last     <= len_last;
            wdata    <= mem_wdata;
            cnt      <= 3'd0;
            asm_data <= 32'd0;
            ram_a    <= mem_addr;
            busy     <= 1'b1;
            if (mem_we) begin
              state    <= WRITE;
              ram_wr   <= 1'b1;
              ram_dout <= mem_wdata[7:0];
            end else begin
              state <= READ;
            end
          end else if (if_req && !if_flush) begin
            owner_if <= 1'b1;
            base     <= if_addr;
            last     <= 2'd3;
            cnt      <= 3'd0;
            asm_data <= 32'd0;
            ram_a    <= if_addr;
            busy     <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          if (owner_if && if_flush) begin
            // taken jump: drop the fetch and its partial data
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            // RAM data lags the address by one cycle, so capture starts at cnt=1
            if (cnt != 3'd0) asm_data <= assembled;
            if (cnt == {1'b0, last} + 3'd1) begin
              state <= DONE;
              if (owner_if) begin
                if_done <= 1'b1;
                if_data <= assembled;
              end else begin
                mem_done  <= 1'b1;
                mem_rdata <= assembled;
              end
            end else begin
              cnt <= cnt + 3'd1;
              if (cnt < {1'b0, last}) ram_a <= next_addr;
            end
          end
        end
        WRITE: begin
          if (cnt == {1'b0, last}) begin
            ram_wr   <= 1'b0;
            state    <= DONE;
            mem_done <= 1'b1;
          end else begin
            cnt      <= cnt + 3'd1;
            ram_a    <= next_addr;
            ram_dout <= wdata[{wr_idx, 3'b000} +: 8];
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: byte RAM model, scoreboard of expected done
// pulses, write beats and read addresses, directed cases plus random traffic.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0, if_done;
  logic [31:0] if_addr = 32'd0, if_data;
  logic        mem_req = 1'b0, mem_we = 1'b0, mem_done;
  logic [31:0] mem_addr = 32'd0, mem_wdata = 32'd0, mem_rdata;
  logic [1:0]  mem_len = 2'd0;
  logic [31:0] ram_a;
  logic        ram_wr, busy;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = 8'd0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_len(mem_len), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
    .busy(busy)
  );

  typedef struct {bit is_if; int cyc; logic [31:0] data; bit chk;} done_t;
  typedef struct {int cyc; logic [31:0] addr; logic [7:0] data;} beat_t;

  done_t       scb[$];
  beat_t       wr_q[$];
  beat_t       rd_q[$];
  logic [7:0]  ram_mem [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [7:0] init_byte(logic [31:0] a);
    case (a)
      32'h1000: return 8'h13;
      32'h1001: return 8'h57;
      32'h1002: return 8'h9B;
      32'h1003: return 8'hDF;
      32'h0007: return 8'hF0;
      default:  return (a[7:0] ^ 8'h5A) + a[15:8] + a[31:24];
    endcase
  endfunction

  function automatic logic [7:0] ram_rd(logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // cycle counter and RAM model (read data appears the cycle after its address)
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_wr) ram_mem[ram_a] = ram_dout;
    ram_din <= ram_rd(ram_a);
  end

  // monitor: pops expectations whenever the DUT presents an event
  always @(negedge clk) begin
    done_t e;
    beat_t b;
    if (if_done || mem_done) begin
      chk("exclusive_done", {31'd0, if_done & mem_done}, 32'd0);
      if (scb.size() == 0) begin
        chk("unexpected_done", {31'd0, if_done | mem_done}, 32'd0);
      end else begin
        e = scb.pop_front();
        chk("done_src", {31'd0, if_done}, {31'd0, e.is_if});
        chk("done_cyc", cyc, e.cyc);
        if (e.chk) chk("rdata", e.is_if ? if_data : mem_rdata, e.data);
        $display("done %s cyc=%0d if_data=%h mem_rdata=%h", e.is_if ? "IF " : "MEM", cyc, if_data, mem_rdata);
      end
    end
    if (ram_wr) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_wr", {31'd0, ram_wr}, 32'd0);
      end else begin
        b = wr_q.pop_front();
        chk("wr_cyc", cyc, b.cyc);
        chk("wr_addr", ram_a, b.addr);
        chk("wr_data", {24'd0, ram_dout}, {24'd0, b.data});
      end
    end
    if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
      b = rd_q.pop_front();
      chk("rd_addr", ram_a, b.addr);
    end
  end

  function automatic int nbytes(logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  // expected events for a MEM transaction granted at edge g (cycle k <-> cyc g+k-1)
  task automatic plan_mem(int g, bit we, logic [31:0] a, logic [1:0] len, logic [31:0] wd);
    int n = nbytes(len);
    logic [31:0] ex = 32'd0;
    beat_t b;
    done_t e;
    for (int i = 0; i < n; i++) begin
      b.cyc  = g + i;
      b.addr = a + 32'(i);
      if (we) begin
        b.data = wd[8*i +: 8];
        wr_q.push_back(b);
        ref_mem[b.addr] = b.data;
      end else begin
        b.data = 8'd0;
        rd_q.push_back(b);
        ex[8*i +: 8] = ref_rd(b.addr);
      end
    end
    e.is_if = 1'b0;
    e.cyc   = we ? g + n : g + n + 1;
    e.data  = ex;
    e.chk   = !we;
    scb.push_back(e);
  endtask

  // expected events for an IF fetch granted at edge g; fk>0 = flushed in cycle fk
  task automatic plan_if(int g, logic [31:0] a, int fk);
    logic [31:0] ex = 32'd0;
    beat_t b;
    done_t e;
    for (int i = 0; i < 4; i++) begin
      b.cyc  = g + i;
      b.addr = a + 32'(i);
      b.data = 8'd0;
      if (fk == 0 || i + 1 <= fk) rd_q.push_back(b);
      ex[8*i +: 8] = ref_rd(b.addr);
    end
    if (fk == 0) begin
      e.is_if = 1'b1;
      e.cyc   = g + 5;
      e.data  = ex;
      e.chk   = 1'b1;
      scb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_mem(bit we, logic [31:0] a, logic [1:0] len, logic [31:0] wd);
    int g;
    int n = nbytes(len);
    wait_idle();
    g = cyc + 1;
    mem_req = 1'b1; mem_we = we; mem_addr = a; mem_len = len; mem_wdata = wd;
    plan_mem(g, we, a, len, wd);
    $display("txn MEM %s addr=%h len=%0d wdata=%h", we ? "store" : "load ", a, len, wd);
    @(negedge clk);
    mem_req = 1'b0;
    wait_cyc((we ? g + n : g + n + 1) + 1);
    chk("busy_after_mem", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_if(logic [31:0] a, int fk);
    int g;
    wait_idle();
    g = cyc + 1;
    if_req = 1'b1; if_addr = a;
    plan_if(g, a, fk);
    $display("txn IF  fetch addr=%h flush_cycle=%0d", a, fk);
    @(negedge clk);
    if_req = 1'b0;
    if (fk != 0) begin
      wait_cyc(g + fk - 1);
      if_flush = 1'b1;
      @(negedge clk);
      if_flush = 1'b0;
      chk("busy_after_flush", {31'd0, busy}, 32'd0);
    end else begin
      wait_cyc(g + 6);
      chk("busy_after_if", {31'd0, busy}, 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(7) == 0) return 32'hFFFFFFFC + 32'($urandom_range(3));
    return 32'h100 + 32'($urandom_range(63));
  endfunction

  initial begin
    int g;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("rst_done", {30'd0, if_done, mem_done}, 32'd0);
    chk("rst_ram_a", ram_a, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // IF word fetch from 0x1000
    do_if(32'h1000, 0);

    // simultaneous IF and MEM requests: store wins, fetch follows
    wait_idle();
    g = cyc + 1;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h20; mem_len = 2'd2; mem_wdata = 32'hAABBCCDD;
    if_req = 1'b1; if_addr = 32'h1000;
    plan_mem(g, 1'b1, 32'h20, 2'd2, 32'hAABBCCDD);
    plan_if(g + 6, 32'h1000, 0);
    $display("txn MEM store + IF fetch simultaneous");
    @(negedge clk);
    mem_req = 1'b0;
    wait_cyc(g + 6);
    if_req = 1'b0;
    wait_cyc(g + 12);
    chk("busy_after_pair", {31'd0, busy}, 32'd0);

    // byte load from 0x7
    do_mem(1'b0, 32'h7, 2'd0, 32'd0);

    // half store across the address wrap, then read it back
    do_mem(1'b1, 32'hFFFFFFFF, 2'd1, 32'h00001234);
    do_mem(1'b0, 32'hFFFFFFFF, 2'd1, 32'd0);

    // fetch flushed in cycle 3 while MEM waits
    wait_idle();
    g = cyc + 1;
    if_req = 1'b1; if_addr = 32'h2000;
    plan_if(g, 32'h2000, 3);
    $display("txn IF  fetch addr=00002000 flushed cycle 3, MEM load pending");
    @(negedge clk);
    if_req = 1'b0;
    wait_cyc(g + 2);
    if_flush = 1'b1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h104; mem_len = 2'd2;
    plan_mem(g + 4, 1'b0, 32'h104, 2'd2, 32'd0);
    @(negedge clk);
    if_flush = 1'b0;
    chk("flush_to_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    mem_req = 1'b0;
    wait_cyc(g + 10);
    chk("busy_after_flush_mem", {31'd0, busy}, 32'd0);

    // asynchronous reset in the middle of a word store
    wait_idle();
    g = cyc + 1;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h9000; mem_len = 2'd2; mem_wdata = 32'h11223344;
    plan_mem(g, 1'b1, 32'h9000, 2'd2, 32'h11223344);
    $display("txn MEM store addr=00009000 aborted by reset in cycle 2");
    @(negedge clk);
    mem_req = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ram_a", ram_a, 32'd0);
    chk("arst_ram_dout", {24'd0, ram_dout}, 32'd0);
    chk("arst_done", {30'd0, if_done, mem_done}, 32'd0);
    chk("arst_if_data", if_data, 32'd0);
    chk("arst_mem_rdata", mem_rdata, 32'd0);
    wr_q.delete();
    rd_q.delete();
    scb.delete();
    for (int i = 1; i < 4; i++) ref_mem.delete(32'h9000 + 32'(i));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_after_reset", {31'd0, busy}, 32'd0);

    // random traffic
    for (int t = 0; t < 60; t++) begin
      int kind = $urandom_range(2);
      repeat ($urandom_range(2)) @(negedge clk);
      if (kind == 0)
        do_if(rand_addr(), ($urandom_range(3) == 0) ? $urandom_range(1, 5) : 0);
      else
        do_mem(kind == 2, rand_addr(), 2'($urandom_range(3)), $urandom);
    end

    repeat (3) @(negedge clk);
    chk("scb_empty", scb.size(), 32'd0);
    chk("wr_q_empty", wr_q.size(), 32'd0);
    chk("rd_q_empty", rd_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
